// File: rtl/sys_types.sv
// Shared types for the feature-map streaming path: window tags, controller
// state encoding and the sliding_window row depth.
package sys_types;

    typedef logic signed [7:0] int8_t;

    // Number of rows held by sliding_window (A0..A3).
    localparam int SW_ROWS = 4;

    localparam int TAG_ROW_W = 10;
    localparam int TAG_COL_W = 8;

    // Position of a window: top row index and strip index.
    typedef struct packed {
        logic [TAG_ROW_W-1:0] row;
        logic [TAG_COL_W-1:0] col;
    } win_tag_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/window_skid_reg.sv
// One-entry data+tag skid register with bypass. When empty the input word
// passes straight through; once captured, the held word is presented until
// popped.
module window_skid_reg #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 18
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              capture,
    input  logic              pop,
    input  logic [DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              full,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag
);

    logic [DATA_W-1:0] data_q;
    logic [TAG_W-1:0]  tag_q;

    // Hold a word that could not be pushed; release it when it is consumed.
    always_ff @(posedge clk) begin
        if (reset) begin
            full   <= 1'b0;
            data_q <= '0;
            tag_q  <= '0;
        end else if (capture) begin
            full   <= 1'b1;
            data_q <= in_data;
            tag_q  <= in_tag;
        end else if (pop) begin
            full   <= 1'b0;
        end
    end

    assign out_data = full ? data_q : in_data;
    assign out_tag  = full ? tag_q  : in_tag;

endmodule

// File: rtl/window_stream_ctrl.sv
// Address generator and flow controller feeding the 4-row sliding_window
// buffer. Walks the map in 4-pixel column strips, top to bottom, and marks
// when the buffered 4x4 window is complete. A one-entry skid register absorbs
// the read already in flight when downstream stalls, so sliding_window is
// never pushed over an unaccepted window. sliding_window sits beside this
// block at the integration level, sharing clk/reset.
module window_stream_ctrl
    import sys_types::*;
#(
    parameter int ADDR_W = 16,
    parameter int ROW_W  = 10,
    parameter int COL_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ROW_W-1:0]  cfg_rows,
    input  logic [COL_W-1:0]  cfg_words,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              sw_valid_in,
    output logic [31:0]       sw_pixels,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [ROW_W-1:0]  win_row,
    output logic [COL_W-1:0]  win_col,
    output logic              win_last,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam int TAG_W = ROW_W + COL_W;

    ctrl_state_e       state;
    logic [ROW_W-1:0]  rows_q;
    logic [COL_W-1:0]  words_q;

    // Read walker: current (r, c) and its address, plus the strip's row-0 address.
    logic [ROW_W-1:0]  rd_r;
    logic [COL_W-1:0]  rd_c;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] col_addr;
    logic              reads_remain;

    // Read in flight (data arrives next cycle) and its tag.
    logic              rd_pending;
    logic [ROW_W-1:0]  pend_r;
    logic [COL_W-1:0]  pend_c;

    logic              skid_full;
    logic [31:0]       sel_data;
    logic [TAG_W-1:0]  sel_tag;
    logic [ROW_W-1:0]  sel_r;
    logic [COL_W-1:0]  sel_c;
    logic [31:0]       pix_q;

    logic cfg_ok, row_end, last_rd, push, capture, pop, accept;

    assign cfg_ok  = (cfg_rows >= ROW_W'(SW_ROWS)) && (cfg_words != '0);
    assign row_end = (rd_r == rows_q - 1'b1);
    assign last_rd = row_end && (rd_c == words_q - 1'b1);

    // A word may go to sliding_window only if no unaccepted window would be disturbed.
    assign push    = (rd_pending | skid_full) & (~win_valid | win_ready);
    assign mem_ren = (state == ST_RUN) & reads_remain & (~(rd_pending | skid_full) | push);
    assign mem_addr = rd_addr;
    assign capture = rd_pending & ~push;
    assign pop     = skid_full & push;
    assign accept  = win_valid & win_ready;

    assign {sel_r, sel_c} = sel_tag;
    assign sw_valid_in = push;
    assign sw_pixels   = push ? sel_data : pix_q;

    window_skid_reg #(.DATA_W(32), .TAG_W(TAG_W)) u_skid (
        .clk      (clk),
        .reset    (reset),
        .capture  (capture),
        .pop      (pop),
        .in_data  (mem_rdata),
        .in_tag   ({pend_r, pend_c}),
        .full     (skid_full),
        .out_data (sel_data),
        .out_tag  (sel_tag)
    );

    // Pass sequencing with registered busy/done/cfg_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            rows_q  <= '0;
            words_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                ST_IDLE: if (start) begin
                    rows_q  <= cfg_rows;
                    words_q <= cfg_words;
                    if (cfg_ok) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end else begin
                        state   <= ST_ERR;
                        cfg_err <= 1'b1;
                        done    <= 1'b1;
                    end
                end
                ST_RUN: if (mem_ren && last_rd) state <= ST_DRAIN;
                ST_DRAIN: if (accept && win_last) begin
                    state <= ST_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Column-strip walker: rows top to bottom, then step to the next strip.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_r         <= '0;
            rd_c         <= '0;
            rd_addr      <= '0;
            col_addr     <= '0;
            reads_remain <= 1'b0;
        end else if (state == ST_IDLE && start && cfg_ok) begin
            rd_r         <= '0;
            rd_c         <= '0;
            rd_addr      <= cfg_base;
            col_addr     <= cfg_base;
            reads_remain <= 1'b1;
        end else if (mem_ren) begin
            if (row_end) begin
                rd_r     <= '0;
                rd_c     <= rd_c + 1'b1;
                rd_addr  <= col_addr + 1'b1;
                col_addr <= col_addr + 1'b1;
                if (last_rd) reads_remain <= 1'b0;
            end else begin
                rd_r    <= rd_r + 1'b1;
                rd_addr <= rd_addr + ADDR_W'(words_q);
            end
        end
    end

    // Track the read in flight so its data can be tagged on arrival.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pending <= 1'b0;
            pend_r     <= '0;
            pend_c     <= '0;
        end else begin
            rd_pending <= mem_ren;
            if (mem_ren) begin
                pend_r <= rd_r;
                pend_c <= rd_c;
            end
        end
    end

    // Window presentation: rows 0..2 of a strip only prime sliding_window.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
            win_last  <= 1'b0;
            pix_q     <= '0;
        end else begin
            if (push) pix_q <= sel_data;
            if (push && sel_r >= ROW_W'(SW_ROWS - 1)) begin
                win_valid <= 1'b1;
                win_row   <= sel_r - ROW_W'(SW_ROWS - 1);
                win_col   <= sel_c;
                win_last  <= (sel_r == rows_q - 1'b1) && (sel_c == words_q - 1'b1);
            end else if (win_ready) begin
                win_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_window_stream_ctrl.sv
// Scoreboard bench for window_stream_ctrl: an SRAM model, a sliding_window
// shift model, expected-address and expected-window queues filled at start,
// and a monitor that pops and compares as the DUT presents reads/windows.
module tb_window_stream_ctrl;

    localparam int ADDR_W = 16;
    localparam int ROW_W  = 10;
    localparam int COL_W  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] cfg_base;
    logic [ROW_W-1:0]  cfg_rows;
    logic [COL_W-1:0]  cfg_words;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              sw_valid_in;
    logic [31:0]       sw_pixels;
    logic              win_valid;
    logic              win_ready;
    logic [ROW_W-1:0]  win_row;
    logic [COL_W-1:0]  win_col;
    logic              win_last;
    logic              busy;
    logic              done;
    logic              cfg_err;

    window_stream_ctrl #(.ADDR_W(ADDR_W), .ROW_W(ROW_W), .COL_W(COL_W)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_base(cfg_base),
        .cfg_rows(cfg_rows), .cfg_words(cfg_words), .mem_ren(mem_ren),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .sw_valid_in(sw_valid_in),
        .sw_pixels(sw_pixels), .win_valid(win_valid), .win_ready(win_ready),
        .win_row(win_row), .win_col(win_col), .win_last(win_last),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic             last;
        logic [3:0][31:0] a;
    } win_exp_t;

    logic [ADDR_W-1:0] addr_q[$];
    win_exp_t          win_q[$];

    int n_vec = 0;
    int n_err = 0;
    int n_rd = 0, n_push = 0, n_done = 0;
    int cyc = 0, acc_cyc = 0;
    bit mon_en = 1'b0;
    logic [31:0] a0, a1, a2, a3;

    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
        return {a, a ^ 16'hA5A5};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM: data one cycle after the read enable.
    always @(posedge clk) mem_rdata <= mem_ren ? mem_word(mem_addr) : 32'hDEAD_BEEF;

    // sliding_window model: A0 newest row, A3 oldest.
    always @(posedge clk) begin
        if (reset) begin
            a0 <= '0; a1 <= '0; a2 <= '0; a3 <= '0;
        end else if (sw_valid_in) begin
            a0 <= sw_pixels; a1 <= a0; a2 <= a1; a3 <= a2;
        end
    end

    // Monitor: compare every read and every accepted window against the queues.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_ren) begin
                if (!sw_valid_in) check("slot_free", 64'(n_rd - n_push), 64'd0);
                if (addr_q.size() == 0) check("unexpected_ren", 64'd1, 64'd0);
                else check("mem_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
                n_rd++;
            end
            if (win_valid && !win_ready) check("hold_no_push", 64'(sw_valid_in), 64'd0);
            if (sw_valid_in) n_push++;
            if (win_valid && win_ready) begin
                if (win_q.size() == 0) check("unexpected_win", 64'd1, 64'd0);
                else begin
                    win_exp_t e;
                    e = win_q.pop_front();
                    check("win_row",  64'(win_row),  64'(e.row));
                    check("win_col",  64'(win_col),  64'(e.col));
                    check("win_last", 64'(win_last), 64'(e.last));
                    check("win_A0", 64'(a0), 64'(e.a[0]));
                    check("win_A1", 64'(a1), 64'(e.a[1]));
                    check("win_A2", 64'(a2), 64'(e.a[2]));
                    check("win_A3", 64'(a3), 64'(e.a[3]));
                end
                acc_cyc = cyc;
            end
            if (done) n_done++;
        end
    end

    task automatic pulse_start(input logic [ADDR_W-1:0] base, input int h, input int w);
        @(posedge clk); #1;
        cfg_base = base; cfg_rows = ROW_W'(h); cfg_words = COL_W'(w); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: ready always; 1: stall 5 cycles at first window; 2: random ready.
    task automatic run_pass(input logic [ADDR_W-1:0] base, input int h, input int w, input int mode);
        int  d0, bp;
        bit  seen, got, held;
        d0 = n_done; bp = 0; seen = 0; got = 0;
        for (int c = 0; c < w; c++)
            for (int r = 0; r < h; r++)
                addr_q.push_back(ADDR_W'(int'(base) + r * w + c));
        for (int c = 0; c < w; c++)
            for (int r = 3; r < h; r++) begin
                win_exp_t e;
                e.row  = ROW_W'(r - 3);
                e.col  = COL_W'(c);
                e.last = (r == h - 1) && (c == w - 1);
                for (int k = 0; k < 4; k++)
                    e.a[k] = mem_word(ADDR_W'(int'(base) + (r - k) * w + c));
                win_q.push_back(e);
            end
        win_ready = 1'b1;
        pulse_start(base, h, w);
        check("busy_run", 64'(busy), 64'd1);
        for (int i = 0; i < 800 && !got; i++) begin
            held = 1'b0;
            case (mode)
                1: begin
                    if (win_valid && !seen) begin seen = 1'b1; bp = 5; end
                    if (bp > 0) begin win_ready = 1'b0; bp--; held = 1'b1; end
                    else win_ready = 1'b1;
                end
                2: win_ready = 1'($urandom_range(0, 1));
                default: win_ready = 1'b1;
            endcase
            @(negedge clk);
            if (held) begin
                check("bp_valid", 64'(win_valid), 64'd1);
                check("bp_row",   64'(win_row),   64'd0);
            end
            if (done) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("done_seen", 64'(got), 64'd1);
        check("done_latency", 64'(cyc - acc_cyc), 64'd1);
        check("addr_left", 64'(addr_q.size()), 64'd0);
        check("win_left",  64'(win_q.size()), 64'd0);
        @(posedge clk); #1;
        win_ready = 1'b1;
        @(negedge clk);
        check("done_once", 64'(n_done - d0), 64'd1);
        check("idle_busy", 64'(busy), 64'd0);
        addr_q.delete();
        win_q.delete();
    endtask

    task automatic err_pass(input int h, input int w);
        pulse_start(16'h0040, h, w);
        @(negedge clk);
        check("err_cfg_err", 64'(cfg_err), 64'd1);
        check("err_done",    64'(done),    64'd1);
        check("err_busy",    64'(busy),    64'd0);
        @(negedge clk);
        check("err_cfg_err_clr", 64'(cfg_err), 64'd0);
        check("err_done_clr",    64'(done),    64'd0);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ren"},   64'(mem_ren),     64'd0);
        check({tag, "_addr"},  64'(mem_addr),    64'd0);
        check({tag, "_swv"},   64'(sw_valid_in), 64'd0);
        check({tag, "_swpix"}, 64'(sw_pixels),   64'd0);
        check({tag, "_wv"},    64'(win_valid),   64'd0);
        check({tag, "_wrow"},  64'(win_row),     64'd0);
        check({tag, "_wcol"},  64'(win_col),     64'd0);
        check({tag, "_wlast"}, 64'(win_last),    64'd0);
        check({tag, "_busy"},  64'(busy),        64'd0);
        check({tag, "_done"},  64'(done),        64'd0);
        check({tag, "_err"},   64'(cfg_err),     64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; win_ready = 1'b1;
        cfg_base = '0; cfg_rows = '0; cfg_words = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        mon_en = 1'b1;

        run_pass(16'h0010, 4, 1, 0);
        run_pass(16'h0100, 6, 2, 0);
        run_pass(16'h0200, 8, 1, 1);
        run_pass(16'h0300, 7, 3, 2);
        run_pass(16'hFFFE, 4, 2, 0);   // address wraps past 0xFFFF
        err_pass(3, 2);
        err_pass(5, 0);

        // Reset in the middle of a strip, then a clean pass.
        mon_en = 1'b0;
        pulse_start(16'h0100, 6, 2);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_quiet("midreset");
        #1 reset = 1'b0;
        n_rd = 0; n_push = 0;
        addr_q.delete();
        win_q.delete();
        mon_en = 1'b1;
        run_pass(16'h0100, 6, 2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL timeout: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1);
    end

endmodule
